tick_period_monitor: RTL
========================

// Module: tick_period_monitor
// PURPOSE
//  Receiving end of the clock-divider strobe ("flag") interface. Measures the clk-cycle distance between
//  rising edges of flag_in and checks it against a nominal divide ratio. Reports lock, a sticky fault and
//  per-period measurements. Sits downstream of any divider whose tick drives timing-critical logic.
// PARAMETERS
//  CNT_WIDTH   16  width of period counter, nominal_period, period_out
//  TOL         1   allowed |measured - nominal| for a "good" period (cycles)
//  LOCK_COUNT  4   consecutive good periods needed ARM/ACQUIRE -> LOCKED
//  FAULT_COUNT 2   consecutive bad periods needed LOCKED -> FAULT
// PORTS
//  clk             in   1          system clock
//  n_rst           in   1          asynchronous active-low reset
//  s_rst           in   1          synchronous clear, priority over enable
//  enable          in   1          monitor enable; 0 forces IDLE
//  flag_in         in   1          divider strobe; pulse or level, only rising edges count
//  nominal_period  in   CNT_WIDTH  expected period; latched on IDLE->ARM, must be >= 2
//  period_valid    out  1          1-cycle pulse: period_out updated
//  period_out      out  CNT_WIDTH  last measured period (cycles)
//  locked          out  1          in LOCKED state
//  fault           out  1          in FAULT state (sticky)
//  err_count       out  8          bad periods since leaving IDLE, saturates at 255
// BEHAVIOUR
//  - n_rst=0 or s_rst=1: all outputs 0, state IDLE, counters 0, flag_prev 0 (s_rst at next edge).
//  - Edge: edge = flag_in & ~flag_prev (flag_prev registered). No synchroniser; flag_in is same-clock.
//  - Counter: cleared on edge, else +1, saturating at all-ones. Period = count+1 on edge cycle;
//    edges N cycles apart give period N. period_out/period_valid registered: valid 1 cycle after edge.
//  - Good: |period - nom_q| <= TOL, compared at CNT_WIDTH+1 bits (no wrap).
//  - Timeout: in ACQUIRE/LOCKED, no edge while count+1 == nom_q+TOL+1 -> one bad period, count<=0,
//    no period_valid. Edge and timeout same cycle: edge wins.
//  - States:
//    IDLE    enable=1 -> ARM (latch nom_q, clear good/bad counts, err_count).
//    ARM     first edge -> ACQUIRE (no measurement: no prior edge).
//    ACQUIRE good: good_cnt++; good_cnt reaching LOCK_COUNT -> LOCKED. bad: good_cnt<=0, err_count++.
//    LOCKED  bad: bad_cnt++, err_count++; bad_cnt reaching FAULT_COUNT -> FAULT. good: bad_cnt<=0.
//    FAULT   measurements/period_valid continue; state stays until s_rst or enable=0.
//  - enable=0 from any state -> IDLE next cycle: locked/fault 0, period_out and err_count hold.
//  - locked/fault are registered state decodes, valid the cycle after the transition.
//  - nominal_period changes outside IDLE are ignored.
// STRUCTURE
//  - Package tick_mon_pkg: typedef enum logic [2:0] {IDLE, ARM, ACQUIRE, LOCKED, FAULT} tick_mon_state_t;
//    localparam ERR_W = 8.
//  - Sub-module flag_edge_detect (clk, n_rst, s_rst, d, rise): registered prev, combinational rise.
//  - Counter, compare and FSM in this module; one always_ff for state/regs, one always_comb for next-state.
// TESTING (nominal_period=10, TOL=1, LOCK_COUNT=4, FAULT_COUNT=2; clk 6.66 ns)
//  1 n_rst=0 mid-LOCKED -> all outputs 0 immediately; after release, IDLE until enable=1.
//  2 enable=1, 1-cycle flag every 10 clks -> period_valid each edge, period_out=10; locked=1 the cycle
//    after the 5th edge's transition; err_count=0.
//  3 LOCKED, one period 13 then 10s -> err_count=1, locked stays 1; two consecutive 13s -> fault=1, locked=0.
//  4 LOCKED, flag stops at edge t0 -> timeouts at t0+12, t0+24; fault=1 after the second, no period_valid.
//  5 FAULT, s_rst=1 one cycle -> fault=0, err_count=0, IDLE; re-lock with period 9 and 11 (within TOL).
//  6 flag held high 3 clks per 10-clk period -> period_out=10; flag stuck high -> timeout only;
//    enable=0 in ACQUIRE -> IDLE, then re-enable needs 4 fresh good periods.

Source files
------------

// File: rtl/tick_mon_pkg.sv
// tick_mon_pkg: shared state encoding and widths for the tick period monitor
`timescale 1ns/1ps
package tick_mon_pkg;
    typedef enum logic [2:0] {IDLE, ARM, ACQUIRE, LOCKED, FAULT} tick_mon_state_t;
    localparam int ERR_W = 8;
endpackage

// File: rtl/flag_edge_detect.sv
// flag_edge_detect: registered previous level with combinational rising-edge output
`timescale 1ns/1ps
module flag_edge_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic s_rst,
    input  logic d,
    output logic rise
);
    logic prev;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst)
            prev <= 1'b0;
        else
            prev <= s_rst ? 1'b0 : d;
    assign rise = d & ~prev;
endmodule

// File: rtl/tick_period_monitor.sv
// tick_period_monitor: measures flag_in rising-edge spacing against a nominal period, reports lock and sticky fault
`timescale 1ns/1ps
module tick_period_monitor
    import tick_mon_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int TOL         = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int FAULT_COUNT = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 s_rst,
    input  logic                 enable,
    input  logic                 flag_in,
    input  logic [CNT_WIDTH-1:0] nominal_period,
    output logic                 period_valid,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic                 locked,
    output logic                 fault,
    output logic [ERR_W-1:0]     err_count
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(FAULT_COUNT + 1);
    tick_mon_state_t state, state_n;
    logic [CNT_WIDTH-1:0] nom_q, cnt;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic [CNT_WIDTH:0] period, nom_x, diff;
    logic rise, meas, tmo, good, gd, bad;
    flag_edge_detect u_edge (
        .clk   (clk),
        .n_rst (n_rst),
        .s_rst (s_rst),
        .d     (flag_in),
        .rise  (rise)
    );
    assign nom_x  = {1'b0, nom_q};
    assign period = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
    assign diff   = period >= nom_x ? period - nom_x : nom_x - period;
    assign good   = diff <= (CNT_WIDTH+1)'(TOL);
    assign meas   = enable && rise && (state inside {ACQUIRE, LOCKED, FAULT});
    assign tmo    = enable && !rise && (state inside {ACQUIRE, LOCKED}) &&
                    period == nom_x + (CNT_WIDTH+1)'(TOL + 1);
    assign gd     = meas && good;
    assign bad    = (meas && !good) || tmo;
    always_comb begin
        state_n = state;
        if (!enable)
            state_n = IDLE;
        else
            case (state)
                IDLE:    state_n = ARM;
                ARM:     state_n = rise ? ACQUIRE : ARM;
                ACQUIRE: state_n = gd && good_cnt == GW'(LOCK_COUNT - 1) ? LOCKED : ACQUIRE;
                LOCKED:  state_n = bad && bad_cnt == BW'(FAULT_COUNT - 1) ? FAULT : LOCKED;
                default: state_n = state;
            endcase
    end
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst || s_rst) begin
            state        <= IDLE;
            nom_q        <= '0;
            cnt          <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            period_valid <= 1'b0;
            period_out   <= '0;
            locked       <= 1'b0;
            fault        <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_n;
            locked       <= state_n == LOCKED;
            fault        <= state_n == FAULT;
            nom_q        <= state == IDLE && enable ? nominal_period : nom_q;
            cnt          <= state == IDLE || !enable || rise || tmo ? '0 : cnt + CNT_WIDTH'(!(&cnt));
            period_valid <= meas;
            period_out   <= !meas ? period_out : period[CNT_WIDTH] ? '1 : period[CNT_WIDTH-1:0];
            good_cnt     <= state == IDLE ? '0 :
                            state == ACQUIRE && gd ? good_cnt + GW'(1) :
                            state == ACQUIRE && bad ? '0 : good_cnt;
            bad_cnt      <= state == IDLE ? '0 :
                            state == LOCKED && bad ? bad_cnt + BW'(1) :
                            state == LOCKED && gd ? '0 : bad_cnt;
            err_count    <= state == IDLE ? (enable ? '0 : err_count) :
                            bad && !(&err_count) ? err_count + ERR_W'(1) : err_count;
        end
endmodule
